// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin grant between the instruction (m0) and
// data (m1) connectors, with a stall watchdog that answers a silent slave with err.
module wb_arbiter_2m #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic [31:2] m0_addr_i,
    input  logic [2:0]  m0_cti_i,
    input  logic [1:0]  m0_bte_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic [31:2] m1_addr_i,
    input  logic [2:0]  m1_cti_i,
    input  logic [1:0]  m1_bte_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:2] s_addr_o,
    output logic [2:0]  s_cti_o,
    output logic [1:0]  s_bte_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_data_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,
    input  logic        s_err_i
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, TOUT} state_t;

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic [15:0] tmo_count;
    logic        stalled;
    logic        timeout_hit;

    // A strobe is stalled when the granted master is waiting and the slave stays silent.
    always_comb begin
        stalled = 1'b0;
        case (state)
            GNT0:    stalled = m0_stb_i & ~s_ack_i & ~s_err_i;
            GNT1:    stalled = m1_stb_i & ~s_ack_i & ~s_err_i;
            default: stalled = 1'b0;
        endcase
        timeout_hit = stalled && (tmo_count == 16'(TIMEOUT - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    state_next = last_grant ? GNT0 : GNT1;
                else if (m0_cyc_i)
                    state_next = GNT0;
                else if (m1_cyc_i)
                    state_next = GNT1;
            end
            GNT0: begin
                if (!m0_cyc_i)
                    state_next = m1_cyc_i ? GNT1 : IDLE;
                else if (timeout_hit)
                    state_next = TOUT;
            end
            GNT1: begin
                if (!m1_cyc_i)
                    state_next = m0_cyc_i ? GNT0 : IDLE;
                else if (timeout_hit)
                    state_next = TOUT;
            end
            default: state_next = IDLE;
        endcase
    end

    // last_grant also identifies which master owns the err pulse while in TOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            tmo_count  <= 16'd0;
        end else begin
            state <= state_next;
            if (state_next == GNT0)
                last_grant <= 1'b0;
            else if (state_next == GNT1)
                last_grant <= 1'b1;
            if ((state_next != state) || !stalled)
                tmo_count <= 16'd0;
            else
                tmo_count <= tmo_count + 16'd1;
        end
    end

    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_cti_o   = '0;
        s_bte_o   = '0;
        s_sel_o   = '0;
        s_data_o  = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m0_data_o = '0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        m1_data_o = '0;
        case (state)
            GNT0: begin
                s_cyc_o   = m0_cyc_i;
                s_stb_o   = m0_stb_i;
                s_we_o    = m0_we_i;
                s_addr_o  = m0_addr_i;
                s_cti_o   = m0_cti_i;
                s_bte_o   = m0_bte_i;
                s_sel_o   = m0_sel_i;
                s_data_o  = m0_data_i;
                m0_ack_o  = s_ack_i;
                m0_err_o  = s_err_i;
                m0_data_o = s_data_i;
            end
            GNT1: begin
                s_cyc_o   = m1_cyc_i;
                s_stb_o   = m1_stb_i;
                s_we_o    = m1_we_i;
                s_addr_o  = m1_addr_i;
                s_cti_o   = m1_cti_i;
                s_bte_o   = m1_bte_i;
                s_sel_o   = m1_sel_i;
                s_data_o  = m1_data_i;
                m1_ack_o  = s_ack_i;
                m1_err_o  = s_err_i;
                m1_data_o = s_data_i;
            end
            TOUT: begin
                m0_err_o = ~last_grant;
                m1_err_o = last_grant;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Scoreboard bench for wb_arbiter_2m: directed traffic from both masters, with
// expected master responses queued at drive time and matched as they appear.
module tb_wb_arbiter_2m;

    logic        clk;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:2] m0_addr, m1_addr;
    logic [2:0]  m0_cti, m1_cti;
    logic [1:0]  m0_bte, m1_bte;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_wdata, m1_wdata;
    logic [31:0] m0_data_o, m1_data_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:2] s_addr_o;
    logic [2:0]  s_cti_o;
    logic [1:0]  s_bte_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_data_o;
    logic [31:0] s_data_i;
    logic        s_ack_i, s_err_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          master;
        logic        ack;
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t sb[$];
    resp_t mon_entry;
    int    mon_master;

    wb_arbiter_2m #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_addr_i(m0_addr), .m0_cti_i(m0_cti),
        .m0_bte_i(m0_bte), .m0_sel_i(m0_sel), .m0_we_i(m0_we), .m0_data_i(m0_wdata),
        .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_addr_i(m1_addr), .m1_cti_i(m1_cti),
        .m1_bte_i(m1_bte), .m1_sel_i(m1_sel), .m1_we_i(m1_we), .m1_data_i(m1_wdata),
        .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
        .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_sel_o(s_sel_o), .s_data_o(s_data_o),
        .s_data_i(s_data_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic we,
                                 input logic [31:2] addr, input logic [3:0] sel, input logic [31:0] wdata);
        if (m == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_addr = addr; m0_sel = sel; m0_wdata = wdata;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_addr = addr; m1_sel = sel; m1_wdata = wdata;
        end
    endtask

    task automatic slaveRespond(input logic ack, input logic err, input logic [31:0] data);
        s_ack_i  = ack;
        s_err_i  = err;
        s_data_i = data;
    endtask

    task automatic expectResp(input int m, input logic ack, input logic err, input logic [31:0] data);
        resp_t e;
        e.master = m; e.ack = ack; e.err = err; e.data = data;
        sb.push_back(e);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Any ack/err seen by a master must match the oldest queued expectation.
    always @(negedge clk) begin
        if (m0_ack_o || m0_err_o || m1_ack_o || m1_err_o) begin
            checkOutput("resp_dual", 32'((m0_ack_o | m0_err_o) & (m1_ack_o | m1_err_o)), 32'd0);
            checkOutput("resp_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                mon_entry  = sb.pop_front();
                mon_master = (m1_ack_o || m1_err_o) ? 1 : 0;
                checkOutput("resp_master", 32'(mon_master), 32'(mon_entry.master));
                checkOutput("resp_ack", 32'(mon_master == 1 ? m1_ack_o : m0_ack_o), 32'(mon_entry.ack));
                checkOutput("resp_err", 32'(mon_master == 1 ? m1_err_o : m0_err_o), 32'(mon_entry.err));
                checkOutput("resp_data", mon_master == 1 ? m1_data_o : m0_data_o, mon_entry.data);
            end
        end
    end

    initial begin
        rst = 1'b1;
        m0_cti = 3'b000; m0_bte = 2'b00; m1_cti = 3'b111; m1_bte = 2'b01;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
        slaveRespond(1'b0, 1'b0, 32'h0);
        #2;
        checkOutput("rst_s_cyc", 32'(s_cyc_o), 32'd0);
        checkOutput("rst_m0_ack", 32'(m0_ack_o), 32'd0);
        checkOutput("rst_m1_err", 32'(m1_err_o), 32'd0);

        // Requests and slave activity during reset must not leak through.
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 30'h100, 4'hF, 32'hA5A5A5A5);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 30'h200, 4'hF, 32'h0);
        slaveRespond(1'b1, 1'b0, 32'h77777777);
        nextCycle();
        checkOutput("rst_hold_s_cyc", 32'(s_cyc_o), 32'd0);
        checkOutput("rst_hold_s_data", s_data_o, 32'd0);
        checkOutput("rst_hold_m0_data", m0_data_o, 32'd0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
        slaveRespond(1'b0, 1'b0, 32'h0);
        rst = 1'b0;

        $display("[TB] first tie and handover");
        nextCycle();
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 30'h100, 4'hF, 32'h0);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 30'h200, 4'hF, 32'h0);
        #1;
        checkOutput("tie_idle_s_cyc", 32'(s_cyc_o), 32'd0);
        nextCycle();
        checkOutput("tie1_addr", 32'(s_addr_o), 32'h100);
        checkOutput("tie1_cti", 32'(s_cti_o), 32'd0);
        slaveRespond(1'b1, 1'b0, 32'h11110000);
        expectResp(0, 1'b1, 1'b0, 32'h11110000);
        #1;
        checkOutput("tie1_m1_stall", 32'(m1_ack_o), 32'd0);
        nextCycle();
        slaveRespond(1'b0, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 30'h100, 4'hF, 32'h0);
        #1;
        checkOutput("m0_release_s_cyc", 32'(s_cyc_o), 32'd0);
        nextCycle();
        checkOutput("handover_s_cyc", 32'(s_cyc_o), 32'd1);
        checkOutput("handover_addr", 32'(s_addr_o), 32'h200);
        checkOutput("handover_bte", 32'(s_bte_o), 32'd1);
        slaveRespond(1'b1, 1'b0, 32'h22220000);
        expectResp(1, 1'b1, 1'b0, 32'h22220000);
        nextCycle();
        slaveRespond(1'b0, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 30'h200, 4'hF, 32'h0);
        nextCycle();
        checkOutput("idle_gap_s_cyc", 32'(s_cyc_o), 32'd0);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 30'h100, 4'hF, 32'h0);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 30'h200, 4'hF, 32'h0);
        nextCycle();
        checkOutput("tie2_addr", 32'(s_addr_o), 32'h100);
        slaveRespond(1'b1, 1'b0, 32'h33330000);
        expectResp(0, 1'b1, 1'b0, 32'h33330000);
        nextCycle();
        slaveRespond(1'b0, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
        nextCycle();

        $display("[TB] m0 single read");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 30'h400, 4'hF, 32'h0);
        #1;
        checkOutput("rd_req_s_cyc", 32'(s_cyc_o), 32'd0);
        nextCycle();
        checkOutput("rd_grant_s_cyc", 32'(s_cyc_o), 32'd1);
        checkOutput("rd_grant_addr", 32'(s_addr_o), 32'h400);
        checkOutput("rd_grant_we", 32'(s_we_o), 32'd0);
        nextCycle();
        slaveRespond(1'b1, 1'b0, 32'hDEADBEEF);
        expectResp(0, 1'b1, 1'b0, 32'hDEADBEEF);
        #1;
        checkOutput("rd_m0_data", m0_data_o, 32'hDEADBEEF);
        checkOutput("rd_m0_ack", 32'(m0_ack_o), 32'd1);
        checkOutput("rd_m1_ack", 32'(m1_ack_o), 32'd0);
        checkOutput("rd_m1_data", m1_data_o, 32'd0);
        nextCycle();
        slaveRespond(1'b0, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
        nextCycle();

        $display("[TB] m1 write while m0 waits");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 30'h500, 4'hF, 32'h0);
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 30'h600, 4'b1100, 32'h12340000);
        nextCycle();
        checkOutput("wr_sel", 32'(s_sel_o), 32'hC);
        checkOutput("wr_we", 32'(s_we_o), 32'd1);
        checkOutput("wr_data", s_data_o, 32'h12340000);
        checkOutput("wr_addr", 32'(s_addr_o), 32'h600);
        slaveRespond(1'b1, 1'b0, 32'h0BADF00D);
        expectResp(1, 1'b1, 1'b0, 32'h0BADF00D);
        #1;
        checkOutput("wr_m0_stalled", 32'(m0_ack_o), 32'd0);
        nextCycle();
        slaveRespond(1'b0, 1'b0, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 30'h600, 4'b1100, 32'h12340000);
        #1;
        checkOutput("wr_hold_addr", 32'(s_addr_o), 32'h600);
        nextCycle();
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 30'h600, 4'h0, 32'h0);
        #1;
        checkOutput("wr_release_s_cyc", 32'(s_cyc_o), 32'd0);
        nextCycle();
        checkOutput("m0_after_m1_addr", 32'(s_addr_o), 32'h500);
        checkOutput("m0_after_m1_we", 32'(s_we_o), 32'd0);
        slaveRespond(1'b1, 1'b0, 32'h5555AAAA);
        expectResp(0, 1'b1, 1'b0, 32'h5555AAAA);
        nextCycle();
        slaveRespond(1'b0, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
        nextCycle();

        $display("[TB] m1 timeout");
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 30'h700, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            checkOutput($sformatf("tout_stall%0d_s_cyc", i), 32'(s_cyc_o), 32'd1);
        end
        expectResp(1, 1'b0, 1'b1, 32'h0);
        nextCycle();
        checkOutput("tout_s_cyc", 32'(s_cyc_o), 32'd0);
        checkOutput("tout_s_stb", 32'(s_stb_o), 32'd0);
        checkOutput("tout_m1_err", 32'(m1_err_o), 32'd1);
        checkOutput("tout_m0_err", 32'(m0_err_o), 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
        nextCycle();
        checkOutput("after_tout_m1_err", 32'(m1_err_o), 32'd0);
        checkOutput("after_tout_s_cyc", 32'(s_cyc_o), 32'd0);

        $display("[TB] ack on the timeout cycle");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 30'h800, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            checkOutput($sformatf("race_stall%0d_s_cyc", i), 32'(s_cyc_o), 32'd1);
            if (i == 3) begin
                slaveRespond(1'b1, 1'b0, 32'hCAFEF00D);
                expectResp(0, 1'b1, 1'b0, 32'hCAFEF00D);
                #1;
                checkOutput("race_m0_err", 32'(m0_err_o), 32'd0);
            end
        end
        nextCycle();
        slaveRespond(1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("race_still_granted", 32'(s_cyc_o), 32'd1);
        checkOutput("race_no_err", 32'(m0_err_o), 32'd0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
        nextCycle();
        nextCycle();

        $display("[TB] reset mid-transfer");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 30'h900, 4'hF, 32'h0);
        nextCycle();
        checkOutput("pre_rst_s_cyc", 32'(s_cyc_o), 32'd1);
        nextCycle();
        #1;
        rst = 1'b1;
        slaveRespond(1'b1, 1'b0, 32'hFFFF0000);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 30'hA00, 4'hF, 32'h0);
        #1;
        checkOutput("mid_rst_s_cyc", 32'(s_cyc_o), 32'd0);
        checkOutput("mid_rst_m0_ack", 32'(m0_ack_o), 32'd0);
        checkOutput("mid_rst_m0_data", m0_data_o, 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        slaveRespond(1'b0, 1'b0, 32'h0);
        nextCycle();
        checkOutput("post_rst_tie_addr", 32'(s_addr_o), 32'h900);
        checkOutput("post_rst_m1_ack", 32'(m1_ack_o), 32'd0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
        nextCycle();
        nextCycle();
        @(negedge clk);
        #1;
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 Parameter TIMEOUT, default 255: cycles a granted strobe may wait for ack/err before the arbiter signals a bus error; legal range 2..65535.
REQ-002 clk  input  1  main clock, identical to the wishbone clock.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 m0_cyc_i, m1_cyc_i  input  1 each  master bus-cycle request; m0 is the instruction connector, m1 the data connector.
REQ-005 m0_stb_i, m1_stb_i  input  1 each  master strobe.
REQ-006 m0_addr_i, m1_addr_i  input  [31:2] each  word address.
REQ-007 m0_cti_i, m1_cti_i  input  3 each  cycle type; m0_bte_i, m1_bte_i  input  2 each  burst type.
REQ-008 m0_sel_i, m1_sel_i  input  4 each  byte selects; m0_we_i, m1_we_i  input  1 each  write enable.
REQ-009 m0_data_i, m1_data_i  input  32 each  write data.
REQ-010 m0_data_o, m1_data_o  output  32 each  read data; m0_ack_o, m1_ack_o, m0_err_o, m1_err_o  output  1 each.
REQ-011 s_cyc_o, s_stb_o, s_we_o  output  1 each; s_addr_o [31:2]; s_cti_o 3; s_bte_o 2; s_sel_o 4; s_data_o 32  outputs to the shared slave bus.
REQ-012 s_data_i  input  32; s_ack_i, s_err_i  input  1 each  slave responses.

Function
REQ-013 The FSM SHALL have four states: IDLE, GNT0, GNT1, TOUT; the registered state is the only source of grant.
REQ-014 In IDLE with exactly one cyc_i high, the FSM SHALL move to that master's GNTx on the next posedge.
REQ-015 In IDLE with both cyc_i high, the FSM SHALL grant the master not granted last (round robin); last-grant resets to m1, so m0 wins the first tie.
REQ-016 In GNTx with mx_cyc_i high, the FSM SHALL hold the grant regardless of the other master.
REQ-017 In GNTx with mx_cyc_i low, the FSM SHALL go directly to GNTy if the other master's cyc_i is high, else to IDLE.
REQ-018 In GNTx, all s_* outputs SHALL combinationally equal master x's inputs; in IDLE and TOUT all s_* outputs SHALL be 0.
REQ-019 The granted master's ack_o, err_o and data_o SHALL combinationally equal s_ack_i, s_err_i and s_data_i; the ungranted master SHALL see ack_o=0, err_o=0 and data_o=0.
REQ-020 The timeout counter SHALL increment each cycle in GNTx while mx_stb_i=1 and s_ack_i=0 and s_err_i=0; it SHALL clear on ack, on err, on stb low and on any state change.
REQ-021 When the counter reaches TIMEOUT-1 with no response, the FSM SHALL enter TOUT on the next posedge.
REQ-022 TOUT SHALL last exactly one cycle, drive err_o=1 to the timed-out master only, and then go to IDLE.
REQ-023 When s_ack_i and the timeout condition fall in the same cycle, ack SHALL win: no TOUT is entered and the counter clears.
REQ-024 A master that drops cyc_i mid-transfer SHALL lose the grant per REQ-017; no response is stored or replayed.
REQ-025 Arbitration SHALL add zero wait states: a request seen in IDLE is on the slave bus in the following cycle.

Reset
REQ-026 While rst=1, independent of clk: state=IDLE, last-grant=m1, counter=0, all s_* outputs and all m*_ack_o, m*_err_o and m*_data_o SHALL be 0.
REQ-027 Reset asserted mid-transfer SHALL abort the transfer immediately (s_cyc_o=0 in the same cycle); after release, the FSM SHALL restart from IDLE.

Verification
REQ-028 m0 single read to addr 0x1000>>2, slave acks on the 2nd granted cycle with 0xDEADBEEF -> s_cyc_o=1 one cycle after m0_cyc_i; m0_data_o=0xDEADBEEF with m0_ack_o=1; m1_ack_o=0 throughout.
REQ-029 m0 and m1 raise cyc_i in the same cycle after reset -> m0 is granted first; m0 drops cyc_i -> GNT1 next posedge with no IDLE cycle; a second tie is granted to m0.
REQ-030 m1 write with sel=4'b1100 and data 0x12340000 while m0 requests -> s_sel_o=1100 and s_we_o=1 are m1's; m0 stays stalled until m1 releases.
REQ-031 TIMEOUT=4, m1 strobes and the slave never responds -> TOUT after 4 stalled cycles, m1_err_o=1 for exactly 1 cycle, s_cyc_o=0 during TOUT, then IDLE.
REQ-032 s_ack_i arrives on the exact cycle the counter hits TIMEOUT-1 -> ack is delivered and err_o stays 0.
REQ-033 rst pulsed while GNT0 is waiting -> s_cyc_o=0 and m0_ack_o=0 immediately; after release, a tie grants m0 first.
